// File: rtl/ntps_axi_req_arb.sv
// rtl/ntps_axi_req_arb.sv - two-requester round-robin arbiter onto a single AXI4-Lite master port
// One transaction is in flight at a time; requests are only looked at while idle.
module ntps_axi_req_arb #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [63:0]             wdata,
  output logic [1:0]              ack,
  output logic [31:0]             rdata,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, ACK} state_e;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    sel;
  logic                    unused_resp_lsb;

  assign unused_resp_lsb = m_axi_bresp[0] ^ m_axi_rresp[0];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    // Under contention the requester that did not win last time goes next.
    sel = (req == 2'b11) ? ~last_q : req[1];

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d   = sel;
          last_d    = sel;
          addr_d    = sel ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
          wdata_d   = sel ? wdata[63:32] : wdata[31:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = we[sel] ? WADDR : RADDR;
        end
      end
      WADDR: begin
        aw_done_d = aw_done_q | m_axi_awready;
        w_done_d  = w_done_q | m_axi_wready;
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          rdata_d = '0;
          err_d   = m_axi_bresp[1];
          state_d = ACK;
        end
      end
      RADDR: begin
        if (m_axi_arready) state_d = RDATA;
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          err_d   = m_axi_rresp[1];
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awvalid = (state_q == WADDR) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == WADDR) && !w_done_q;
  assign m_axi_bready  = (state_q == WRESP);
  assign m_axi_arvalid = (state_q == RADDR);
  assign m_axi_rready  = (state_q == RDATA);
  assign ack           = (state_q == ACK) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata         = rdata_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ntps_axi_req_arb.sv
// tb/tb_ntps_axi_req_arb.sv - self-checking bench for ntps_axi_req_arb
module tb_ntps_axi_req_arb;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = '0, we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [63:0]   wdata = '0;
  logic [1:0]    ack;
  logic [31:0]   rdata;
  logic          err;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic          m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_arready = 0, m_axi_rvalid = 0;
  logic [31:0]   m_axi_wdata, m_axi_rdata = '0;
  logic [3:0]    m_axi_wstrb;
  logic [1:0]    m_axi_bresp = '0, m_axi_rresp = '0;

  always #5 clk = ~clk;

  ntps_axi_req_arb #(.ADDR_WIDTH(AW)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .err(err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave responder: configurable ready delays, response issued the cycle after the handshakes.
  int          aw_wait = 0, w_wait = 0, aw_cnt = 0, w_cnt = 0;
  logic        r_hold = 0;
  logic [31:0] s_rdata = '0;
  logic [1:0]  s_resp = '0;
  logic        aw_got = 0, w_got = 0, r_pend = 0;
  logic        p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0;
  logic [31:0] log_awaddr = '0, log_wdata = '0, log_araddr = '0;
  logic [3:0]  log_wstrb = '0;
  int          b_acc = 0;
  int          ack_pulses = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
      aw_got = 0; w_got = 0; r_pend = 0; aw_cnt = 0; w_cnt = 0;
      p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    end else begin
      if (p_aw) begin aw_got = 1; log_awaddr = m_axi_awaddr; end
      if (p_w) begin w_got = 1; log_wdata = m_axi_wdata; log_wstrb = m_axi_wstrb; end
      if (p_b) begin m_axi_bvalid = 0; b_acc++; end
      if (p_ar) begin r_pend = 1; log_araddr = m_axi_araddr; end
      if (p_r) m_axi_rvalid = 0;
      if (aw_got && w_got) begin m_axi_bvalid = 1; m_axi_bresp = s_resp; aw_got = 0; w_got = 0; end
      if (r_pend && !r_hold) begin
        m_axi_rvalid = 1; m_axi_rdata = s_rdata; m_axi_rresp = s_resp; r_pend = 0;
      end
      m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
      aw_cnt = !m_axi_awvalid ? 0 : (m_axi_awready ? aw_cnt : aw_cnt + 1);
      m_axi_wready = m_axi_wvalid && (w_cnt >= w_wait);
      w_cnt = !m_axi_wvalid ? 0 : (m_axi_wready ? w_cnt : w_cnt + 1);
      m_axi_arready = m_axi_arvalid;
      p_aw = m_axi_awvalid && m_axi_awready;
      p_w  = m_axi_wvalid && m_axi_wready;
      p_b  = m_axi_bvalid && m_axi_bready;
      p_ar = m_axi_arvalid && m_axi_arready;
      p_r  = m_axi_rvalid && m_axi_rready;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ack != 2'b00) begin
      ack_pulses++;
      n_cmp++;
      if (ack == 2'b11) begin n_bad++; $display("FAIL ack_onehot: got %b", ack); end
    end
  end

  typedef struct {
    logic [1:0] req, we;
    logic [63:0] addr, wdata;
    logic [31:0] s_rdata;
    logic [1:0] s_resp;
    int aw_wait, w_wait;
    logic [1:0] exp_ack;
    logic [31:0] exp_rdata;
    logic exp_err, exp_write;
    logic [31:0] exp_addr, exp_wdata;
    int exp_lat;
  } vec_t;

  // Drive one request at a negedge while idle, wait (bounded) for the ack pulse.
  task automatic issue(input logic [1:0] r, input logic [1:0] w, input logic [63:0] a, input logic [63:0] d,
                       output logic [1:0] g_ack, output logic [31:0] g_rdata, output logic g_err, output int lat);
    req = r; we = w; addr = a; wdata = d;
    g_ack = '0; g_rdata = '0; g_err = 0; lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      req = 2'b00;
      if (ack != 2'b00) begin g_ack = ack; g_rdata = rdata; g_err = err; lat = i; break; end
    end
    if (lat == 0) begin n_cmp++; n_bad++; $display("FAIL ack_timeout: got none expected ack within 40 cycles"); end
  endtask

  task automatic verify(input string tag, input logic [1:0] g_ack, input logic [31:0] g_rdata, input logic g_err,
                        input int lat, input int b0, input vec_t e);
    check({tag, " ack"}, 64'(g_ack), 64'(e.exp_ack));
    check({tag, " rdata"}, 64'(g_rdata), 64'(e.exp_rdata));
    check({tag, " err"}, 64'(g_err), 64'(e.exp_err));
    check({tag, " latency"}, 64'(lat), 64'(e.exp_lat));
    @(negedge clk);
    check({tag, " rdata_held"}, 64'(rdata), 64'(e.exp_rdata));
    check({tag, " err_held"}, 64'(err), 64'(e.exp_err));
    if (e.exp_write) begin
      check({tag, " awaddr"}, 64'(log_awaddr), 64'(e.exp_addr));
      check({tag, " wdata"}, 64'(log_wdata), 64'(e.exp_wdata));
      check({tag, " wstrb"}, 64'(log_wstrb), 64'h0F);
      check({tag, " b_count"}, 64'(b_acc - b0), 64'd1);
    end else begin
      check({tag, " araddr"}, 64'(log_araddr), 64'(e.exp_addr));
    end
  endtask

  // Reference arbitration: first requester after the last winner, in cyclic order, that is requesting.
  function automatic int pick(input logic [1:0] r, input int last);
    for (int k = 1; k <= 2; k++) if (r[(last + k) % 2]) return (last + k) % 2;
    return -1;
  endfunction

  vec_t vecs[5];
  vec_t e;
  int model_last;
  logic [1:0] g_ack;
  logic [31:0] g_rdata;
  logic g_err;
  int lat, b0, p0, got_n;
  logic [1:0] rr_exp[4];

  initial begin
    vecs[0] = '{2'b01, 2'b01, {32'h0, 32'h10}, {32'h0, 32'hDEADBEEF}, 32'h0, 2'b00, 0, 0,
                2'b01, 32'h0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3};
    vecs[1] = '{2'b10, 2'b00, {32'h24, 32'h0}, 64'h0, 32'h12345678, 2'b10, 0, 0,
                2'b10, 32'h12345678, 1'b1, 1'b0, 32'h24, 32'h0, 3};
    vecs[2] = '{2'b11, 2'b10, {32'h200, 32'h100}, 64'h0, 32'hCAFEF00D, 2'b00, 0, 0,
                2'b01, 32'hCAFEF00D, 1'b0, 1'b0, 32'h100, 32'h0, 3};
    vecs[3] = '{2'b11, 2'b10, {32'h204, 32'h104}, {32'h55AA55AA, 32'h0}, 32'h0, 2'b10, 2, 1,
                2'b10, 32'h0, 1'b1, 1'b1, 32'h204, 32'h55AA55AA, 5};
    vecs[4] = '{2'b01, 2'b01, {32'h0, 32'hFFFFFFFC}, {32'h0, 32'h0BADF00D}, 32'h0, 2'b01, 0, 2,
                2'b01, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h0BADF00D, 5};

    repeat (3) @(negedge clk);
    check("rst ack", 64'(ack), 64'd0);
    check("rst rdata_err", 64'({rdata, err}), 64'd0);
    check("rst valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    check("rst addr_data", 64'({m_axi_awaddr, m_axi_araddr, m_axi_wdata}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      aw_wait = vecs[i].aw_wait; w_wait = vecs[i].w_wait;
      s_rdata = vecs[i].s_rdata; s_resp = vecs[i].s_resp;
      b0 = b_acc;
      issue(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, g_ack, g_rdata, g_err, lat);
      verify($sformatf("vec%0d", i), g_ack, g_rdata, g_err, lat, b0, vecs[i]);
    end

    // wready arrives well before awready: wvalid must drop while awvalid stays up.
    aw_wait = 3; w_wait = 0; s_resp = 2'b00;
    b0 = b_acc; p0 = ack_pulses;
    req = 2'b01; we = 2'b01; addr = {32'h0, 32'h40}; wdata = {32'h0, 32'hA5A5A5A5};
    @(negedge clk); req = 2'b00;
    @(negedge clk);
    check("split wvalid_dropped", 64'(m_axi_wvalid), 64'd0);
    check("split awvalid_held", 64'(m_axi_awvalid), 64'd1);
    got_n = 0;
    for (int i = 0; i < 30 && got_n == 0; i++) begin
      @(negedge clk);
      if (ack != 2'b00) got_n = 1;
    end
    check("split ack_seen", 64'(got_n), 64'd1);
    repeat (4) @(negedge clk);
    check("split b_count", 64'(b_acc - b0), 64'd1);
    check("split ack_count", 64'(ack_pulses - p0), 64'd1);
    check("split awaddr", 64'(log_awaddr), 64'h40);

    // Reset while the read sits in RDATA.
    aw_wait = 0; w_wait = 0; r_hold = 1; s_rdata = 32'h77777777;
    req = 2'b10; we = 2'b00; addr = {32'h88, 32'h0};
    @(negedge clk); req = 2'b00;
    repeat (2) @(negedge clk);
    check("midrst in_rdata", 64'(m_axi_rready), 64'd1);
    p0 = ack_pulses;
    rst_n = 1'b0;
    #1;
    check("midrst outputs", 64'({ack, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'd0);
    check("midrst data", 64'({rdata, m_axi_araddr}), 64'd0);
    repeat (2) @(negedge clk);
    r_hold = 0; rst_n = 1'b1;
    @(negedge clk);
    check("midrst no_ack", 64'(ack_pulses - p0), 64'd0);

    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    req = 2'b11; we = 2'b00; addr = {32'h300, 32'h200};
    got_n = 0;
    for (int i = 0; i < 80 && got_n < 4; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        check($sformatf("rr grant%0d", got_n), 64'(ack), 64'(rr_exp[got_n]));
        got_n++;
        if (got_n == 4) req = 2'b00;
      end
    end
    check("rr four_acks", 64'(got_n), 64'd4);
    @(negedge clk);
    model_last = 1;

    for (int t = 0; t < 30; t++) begin
      int g;
      e.req = 2'($urandom_range(1, 3)); e.we = 2'($urandom);
      e.addr = {$urandom, $urandom}; e.wdata = {$urandom, $urandom};
      s_rdata = $urandom; s_resp = 2'($urandom);
      aw_wait = $urandom_range(0, 2); w_wait = $urandom_range(0, 2);
      g = pick(e.req, model_last);
      model_last = g;
      e.exp_ack = (g == 1) ? 2'b10 : 2'b01;
      e.exp_write = e.we[g];
      e.exp_addr = e.addr[g*32 +: 32];
      e.exp_wdata = e.wdata[g*32 +: 32];
      e.exp_rdata = e.exp_write ? 32'h0 : s_rdata;
      e.exp_err = s_resp[1];
      e.exp_lat = e.exp_write ? 3 + ((aw_wait > w_wait) ? aw_wait : w_wait) : 3;
      b0 = b_acc;
      issue(e.req, e.we, e.addr, e.wdata, g_ack, g_rdata, g_err, lat);
      verify($sformatf("rand%0d", t), g_ack, g_rdata, g_err, lat, b0, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/ntps_axi_req_arb.md
NTPS_AXI_REQ_ARB -- requirements
Module: ntps_axi_req_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the requester and AXI address width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: axi_aclk input 1 (clock); axi_aresetn input 1 (reset).
REQ-003 SHALL provide: req  input  2  per-requester transaction request, bit i = requester i.
REQ-004 SHALL provide: we  input  2  write (1) / read (0), per requester.
REQ-005 SHALL provide: addr  input  2*ADDR_WIDTH  byte address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-006 SHALL provide: wdata  input  64  write data; requester i uses [i*32 +: 32].
REQ-007 SHALL provide: ack  output  2  one-cycle completion pulse to requester i.
REQ-008 SHALL provide: rdata  output  32  read data, shared by both requesters, valid with ack.
REQ-009 SHALL provide: err  output  1  response error, shared by both requesters, valid with ack.
REQ-010 SHALL provide AXI4-Lite master signals: m_axi_awaddr out ADDR_WIDTH; m_axi_awvalid out 1; m_axi_awready in 1.
REQ-011 SHALL provide: m_axi_wdata out 32; m_axi_wstrb out 4; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-012 SHALL provide: m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.
REQ-013 SHALL provide: m_axi_araddr out ADDR_WIDTH; m_axi_arvalid out 1; m_axi_arready in 1.
REQ-014 SHALL provide: m_axi_rdata in 32; m_axi_rresp in 2; m_axi_rvalid in 1; m_axi_rready out 1.

Function
REQ-015 SHALL implement FSM states IDLE, WADDR, WRESP, RADDR, RDATA, ACK, with at most one AXI transaction outstanding.
REQ-016 SHALL, in IDLE, select a requester whose req bit is set; if exactly one is set, that requester is granted.
REQ-017 SHALL, when both req bits are set, grant the requester other than last_grant (round-robin); last_grant resets to 1, so requester 0 wins the first contention.
REQ-018 SHALL, on grant, register the granted addr, wdata and we and update last_grant, then move to WADDR if we=1, else RADDR.
REQ-019 SHALL, in WADDR, assert awvalid and wvalid together from the first WADDR cycle, drop each independently after its own ready handshake, and enter WRESP once both handshakes have completed, including when both complete in the same cycle.
REQ-020 SHALL drive m_axi_wstrb = 4'hF constantly.
REQ-021 SHALL, in WRESP, assert bready and move to ACK on bvalid, capturing err = bresp[1]; rdata is set to 0.
REQ-022 SHALL, in RADDR, assert arvalid until arready, then enter RDATA.
REQ-023 SHALL, in RDATA, assert rready and move to ACK on rvalid, capturing rdata = m_axi_rdata and err = rresp[1].
REQ-024 SHALL, in ACK, pulse ack[grant] for exactly one cycle and return to IDLE; a new grant can occur in the following IDLE cycle.
REQ-025 SHALL hold every AXI valid signal stable until its handshake, per AXI4-Lite.
REQ-026 SHALL complete a transaction with a zero-wait-state slave so that ack rises 3 cycles after the cycle in which req was sampled in IDLE.
REQ-027 SHALL treat req as sampled only in IDLE; if a requester deasserts req after grant, the transaction still completes and ack still pulses.
REQ-028 SHALL keep rdata and err stable from the ACK cycle until the next ACK.
REQ-029 SHALL pass addr through unmodified; the block performs no address decoding.

Reset
REQ-030 SHALL, while axi_aresetn=0, hold the FSM in IDLE, all valid/ready outputs at 0, ack=0, rdata=0, err=0, all AXI address/data outputs at 0, and last_grant=1.
REQ-031 SHALL, on reset asserted mid-transaction, drop all outputs immediately with no ack; the pending transaction is discarded.

Verification
REQ-032 SHALL cover: req=2'b01, we[0]=1, addr0=0x10, wdata0=0xDEADBEEF, zero-wait slave with bresp=0 -> awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF, ack=2'b01 three cycles after sampling, err=0.
REQ-033 SHALL cover: req=2'b10 read addr1=0x24, slave rdata=0x12345678, rresp=2'b10 -> araddr=0x24, ack=2'b10, rdata=0x12345678, err=1.
REQ-034 SHALL cover: req=2'b11 held for four transactions -> grant order 0,1,0,1 and no cycle with both ack bits set.
REQ-035 SHALL cover: write with wready asserted 3 cycles before awready -> wvalid drops after its handshake, awvalid is held, exactly one bvalid is accepted, single ack.
REQ-036 SHALL cover: axi_aresetn pulsed low while in RDATA -> all outputs 0, no ack; after release, req=2'b11 -> requester 0 granted first.
